encoder_4x2_rr: RTL
===================

# encoder_4x2_rr

Registered 4-to-2 encoder with round-robin priority and a valid/ready output handshake. It is the inverse of the 2x4 decoder: it accepts up to four request lines, gated by an enable, and returns the 2-bit index of the granted line. It sits wherever one-hot or multi-hot select lines must be collapsed back to a binary code for a downstream consumer that can stall.

## Interface
Parameters:
- ROUND_ROBIN, default 1. 1 = rotating priority starting at the pointer; 0 = fixed priority where the lowest index wins and the pointer is ignored.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- en  input  1  enable; requests are sampled only when en=1. It plays the same role as the decoder's enable bit a[2].
- a  input  4  request lines; a[i]=1 requests index i.
- out_ready  input  1  downstream can accept y this cycle.
- y  output  2  encoded index of the granted request; registered.
- valid  output  1  y holds an unconsumed result.
- multi  output  1  registered with y; 1 = more than one bit of a was set at capture.

## Operation
- Two states: IDLE (valid=0) and HOLD (valid=1). The rotating pointer ptr[1:0] is internal.
- Capture condition: (state==IDLE, or state==HOLD with out_ready=1) and en=1 and |a=1.
- On capture:
  - Search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4) when ROUND_ROBIN=1, else 0,1,2,3.
  - The first set bit in that order is registered into y.
  - multi is registered as (popcount(a) > 1).
  - valid=1 and the state goes to HOLD.
- Handshake: a transfer occurs on any cycle with valid=1 and out_ready=1.
  - On a transfer, ptr <= y + 1 (2-bit wrap, so 3 → 0).
  - If the capture condition also holds in that cycle, the new grant is computed using the updated pointer (y+1) and the block stays in HOLD. This gives back-to-back throughput of one result per cycle.
  - Otherwise valid <= 0 and the state goes to IDLE.
- While in HOLD with out_ready=0:
  - y, multi and valid stay stable.
  - Changes on a and en are ignored.
- en=0 or a=4'b0000 in IDLE: no state change and ptr is unchanged.
- The pointer advances only on a transfer, never on a capture alone.
- With ROUND_ROBIN=0, ptr still updates but has no effect on the result.

## Timing
- Reset values (at the first clock edge with rst=1): y=2'b00, valid=0, multi=0, ptr=2'b00, state=IDLE.
- rst takes priority over every other input, including reset asserted mid-HOLD. A pending result is discarded without a transfer.
- Latency: a and en sampled at edge N produce valid=1 and the new y/multi immediately after edge N (one cycle).
- No combinational path from a, en or out_ready to any output. All outputs come directly from flops.
- out_ready may be high while valid=0. This has no effect.
- Wrap-around: with ptr=3, search order is 3,0,1,2.
- Simultaneous events:
  - Transfer + capture in one cycle: valid stays 1 and y updates at the same edge.
  - Transfer + no capture: valid falls at that edge.

## Test plan
- Reset/idle:
  - Assert rst for 2 cycles. Check y=00, valid=0, multi=0.
  - Then drive en=1, a=0000 for 3 cycles. Check valid stays 0.
- Enable gating:
  - Drive en=0, a=0100. Check valid=0.
  - Raise en=1. One cycle later check y=10, valid=1, multi=0.
- Round-robin with back-to-back transfers:
  - From reset, hold en=1, a=0110, out_ready=1.
  - Check successive results y=01, 10, 01, 10, each with multi=1 and valid continuously 1.
- Wrap-around:
  - Grant index 3 via a=1000 (y=11) and transfer it, so ptr becomes 0.
  - Drive a=1001. Check y=00.
  - Transfer, then drive a=1001 again. Check y=11, then the following grant y=00.
- Stall:
  - Capture y=01 from a=0010, then hold out_ready=0 for 4 cycles while a changes to 1000.
  - Check y=01 and valid=1 throughout. On out_ready=1, check the transfer occurs and the next result is y=11.
- Reset mid-HOLD and fixed priority:
  - Assert rst while valid=1. Check valid=0 and ptr=0 the following cycle.
  - With ROUND_ROBIN=0, drive a=1100 repeatedly with transfers. Check y=10 every time.

Source files
------------

// File: rtl/encoder_4x2_rr.sv
// encoder_4x2_rr: registered 4-to-2 encoder with rotating (or fixed)
// priority and a valid/ready output handshake. A captured grant is held
// stable until the consumer takes it. A transfer moves the rotating pointer
// to one past the index that was just delivered.
module encoder_4x2_rr #(
  parameter int ROUND_ROBIN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] a,
  input  logic       out_ready,
  output logic [1:0] y,
  output logic       valid,
  output logic       multi
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] y_q, y_d;
  logic       multi_q, multi_d;
  logic       valid_q, valid_d;

  logic       xfer_s;
  logic       capture_s;
  logic [1:0] base_s;
  logic [1:0] grant_s;

  // First set request bit when scanning base, base+1, base+2, base+3 (mod 4).
  function automatic logic [1:0] pick_first(input logic [3:0] req, input logic [1:0] base);
    logic [1:0] idx;
    logic       found;
    pick_first = 2'b00;
    found      = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = base + 2'(k);
      if (!found && req[idx]) begin
        pick_first = idx;
        found      = 1'b1;
      end else begin
        found = found;
      end
    end
  endfunction

  // The request is multi-hot when clearing its lowest set bit leaves something set.
  function automatic logic is_multi_hot(input logic [3:0] req);
    is_multi_hot = ((req & (req - 4'd1)) != 4'b0000);
  endfunction

  // Handshake decode, pointer update, grant search and next-state selection.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    multi_d = multi_q;
    valid_d = valid_q;

    xfer_s    = (state_q == ST_HOLD) && out_ready;
    capture_s = ((state_q == ST_IDLE) || xfer_s) && en && (a != 4'b0000);

    // A transfer moves the pointer past the delivered index. A back-to-back
    // capture in the same cycle already searches from that new position.
    if (xfer_s) begin
      ptr_d = y_q + 2'd1;
    end else begin
      ptr_d = ptr_q;
    end

    if (ROUND_ROBIN != 0) begin
      base_s = ptr_d;
    end else begin
      base_s = 2'b00;
    end
    grant_s = pick_first(a, base_s);

    case (state_q)
      ST_IDLE: begin
        if (capture_s) begin
          state_d = ST_HOLD;
          y_d     = grant_s;
          multi_d = is_multi_hot(a);
          valid_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
      ST_HOLD: begin
        if (capture_s) begin
          state_d = ST_HOLD;
          y_d     = grant_s;
          multi_d = is_multi_hot(a);
          valid_d = 1'b1;
        end else if (xfer_s) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end else begin
          state_d = ST_HOLD;
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State, pointer and output registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'b00;
      y_q     <= 2'b00;
      multi_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      y_q     <= y_d;
      multi_q <= multi_d;
      valid_q <= valid_d;
    end
  end

  assign y     = y_q;
  assign valid = valid_q;
  assign multi = multi_q;

endmodule
